denormalizer: RTL and testbench

DENORMALIZER -- requirements
Module: denormalizer

---
 rtl/norm_pkg.sv | 25 ++
 rtl/denorm_mac.sv | 33 +++
 rtl/denormalizer.sv | 86 ++++++++
 tb/tb_denormalizer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared constants for the sensor normalize/denormalize pair: channel count,
// fixed-point format and per-channel statistics.
package norm_pkg;

  localparam int NCH       = 8;
  localparam int FRAC_BITS = 8;

  // Per-channel offsets are signed, spreads are unsigned.
  localparam logic signed [15:0] MEAN [0:7] = '{
    16'sh0305, -16'sh0058, 16'sh0101, 16'sh013E,
    16'sh0144,  16'sh014E, 16'sh0154, 16'sh0133
  };

  localparam logic [15:0] STD [0:7] = '{
    16'h01F1, 16'h00FD, 16'h0110, 16'h0013,
    16'h002D, 16'h002B, 16'h0024, 16'h0029
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/denorm_mac.sv
// Combinational denormalize datapath for one channel:
// sat16(round(norm * std) + mean).
module denorm_mac #(
  parameter int FRAC_BITS = norm_pkg::FRAC_BITS
) (
  input  logic [15:0] norm,
  input  logic [15:0] std,
  input  logic [15:0] mean,
  output logic [15:0] result
);

  localparam logic signed [32:0] ROUND_HALF = 33'sd1 <<< (FRAC_BITS - 1);

  logic signed [32:0] product;
  logic signed [32:0] rounded;
  logic signed [32:0] shifted;
  logic signed [33:0] sum;

  // std is zero-extended so it is treated as unsigned in the signed multiply.
  always_comb begin
    product = $signed(norm) * $signed({1'b0, std});
    rounded = product + ROUND_HALF;
    shifted = rounded >>> FRAC_BITS;
    sum     = $signed({shifted[32], shifted}) + $signed({{18{mean[15]}}, mean});
    if (sum > 34'sd32767)
      result = 16'h7FFF;
    else if (sum < -34'sd32768)
      result = 16'h8000;
    else
      result = sum[15:0];
  end

endmodule

// File: rtl/denormalizer.sv
// Captures a bank of Q8.8 normalized values and denormalizes them one channel
// per cycle through a single shared datapath.
module denormalizer #(
  parameter int NCH       = norm_pkg::NCH,
  parameter int FRAC_BITS = norm_pkg::FRAC_BITS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_norm [NCH],
  output logic [15:0] o_data [NCH],
  output logic        o_busy,
  output logic        o_finished
);

  import norm_pkg::*;

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [15:0]   bank [NCH];
  logic [15:0]   mac_out;
  logic          last;

  assign last = (cnt == CW'(NCH - 1));

  denorm_mac #(
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .norm  (bank[cnt]),
    .std   (STD[cnt]),
    .mean  (MEAN[cnt]),
    .result(mac_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = CALC;
      CALC:    if (last)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  // Capture bank, channel counter and result registers; reset aborts a run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      o_finished <= 1'b0;
      bank       <= '{default: '0};
      o_data     <= '{default: '0};
    end else begin
      o_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            bank <= i_norm;
            cnt  <= '0;
          end
        end
        CALC: begin
          o_data[cnt] <= mac_out;
          cnt         <= cnt + 1'b1;
          if (last)
            o_finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_denormalizer.sv
// Randomized self-checking bench for denormalizer against an arithmetic
// reference model of the per-channel denormalize rule.
module tb_denormalizer;

  typedef logic [15:0] vec_t [8];

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_norm [8];
  logic [15:0] o_data [8];
  logic        o_busy;
  logic        o_finished;

  int checks = 0;
  int errors = 0;

  int std_ref  [8] = '{497, 253, 272, 19, 45, 43, 36, 41};
  int mean_ref [8] = '{773, -88, 257, 318, 324, 334, 340, 307};

  denormalizer dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_norm    (i_norm),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_finished(o_finished)
  );

  always #5 i_clk = ~i_clk;

  // Floor division by 256 after the half-LSB add, then offset and clamp.
  function automatic logic [15:0] model(input int c, input logic [15:0] n);
    longint p;
    longint q;
    p = longint'($signed(n)) * longint'(std_ref[c]) + 128;
    if (p >= 0) q = p / 256;
    else        q = -((-p + 255) / 256);
    q = q + mean_ref[c];
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  task automatic start_run(input vec_t v);
    @(negedge i_clk);
    i_norm  = v;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_finish(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge i_clk);
      #1;
      cycles++;
      if (o_finished) break;
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_norm  = '{default: '0};
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy);
    end
    checks++;
    if (o_finished !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_finished: got %b expected 0", o_finished);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_data[c] !== 16'h0000) begin
        errors++; $display("[TB] FAIL reset_data ch%0d: got %h expected 0000", c, o_data[c]);
      end
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_zero();
    vec_t v;
    vec_t exp_v;
    int   cyc;
    v     = '{default: '0};
    exp_v = '{16'h0305, 16'hFFA8, 16'h0101, 16'h013E, 16'h0144, 16'h014E, 16'h0154, 16'h0133};
    start_run(v);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_busy: got %b expected 1", o_busy);
    end
    wait_finish(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++; $display("[TB] FAIL zero_latency: got %0d expected 8", cyc);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_data[c] !== exp_v[c]) begin
        errors++; $display("[TB] FAIL zero_data ch%0d: got %h expected %h", c, o_data[c], exp_v[c]);
      end
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_finished !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_pulse_end: got fin=%b busy=%b expected 0 0", o_finished, o_busy);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ch0_in  [3] = '{16'h0100, 16'h7FFF, 16'h8000};
    logic [15:0] ch3_in  [3] = '{16'hFF00, 16'h0080, 16'hFF80};
    logic [15:0] ch0_exp [3] = '{16'h04F6, 16'h7FFF, 16'h8000};
    logic [15:0] ch3_exp [3] = '{16'h012B, 16'h0148, 16'h0135};
    vec_t v;
    int   cyc;
    for (int r = 0; r < 3; r++) begin
      v    = rand_vec();
      v[0] = ch0_in[r];
      v[3] = ch3_in[r];
      start_run(v);
      wait_finish(cyc);
      checks++;
      if (o_data[0] !== ch0_exp[r]) begin
        errors++; $display("[TB] FAIL directed%0d_ch0: got %h expected %h", r, o_data[0], ch0_exp[r]);
      end
      checks++;
      if (o_data[3] !== ch3_exp[r]) begin
        errors++; $display("[TB] FAIL directed%0d_ch3: got %h expected %h", r, o_data[3], ch3_exp[r]);
      end
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (o_data[c] !== model(c, v[c])) begin
          errors++; $display("[TB] FAIL directed%0d_model ch%0d: got %h expected %h", r, c, o_data[c], model(c, v[c]));
        end
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_random();
    vec_t v;
    int   cyc;
    for (int r = 0; r < 8; r++) begin
      v = rand_vec();
      start_run(v);
      wait_finish(cyc);
      checks++;
      if (cyc !== 8) begin
        errors++; $display("[TB] FAIL random%0d_latency: got %0d expected 8", r, cyc);
      end
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (o_data[c] !== model(c, v[c])) begin
          errors++; $display("[TB] FAIL random%0d ch%0d: got %h expected %h", r, c, o_data[c], model(c, v[c]));
        end
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    vec_t a;
    vec_t b;
    int   cyc;
    a = rand_vec();
    b = rand_vec();
    start_run(a);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_norm  = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_finish(cyc);
    checks++;
    if (cyc !== 5) begin
      errors++; $display("[TB] FAIL ignore_latency: got %0d expected 5", cyc);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_data[c] !== model(c, a[c])) begin
        errors++; $display("[TB] FAIL ignore_data ch%0d: got %h expected %h", c, o_data[c], model(c, a[c]));
      end
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_finished !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_single_pulse: got %b expected 0", o_finished);
    end
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_not_queued: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_reset_abort();
    vec_t a;
    vec_t b;
    vec_t cv;
    int   cyc;
    bit   seen_fin;
    a = rand_vec();
    b = rand_vec();
    cv = rand_vec();
    start_run(a);
    wait_finish(cyc);
    @(posedge i_clk);
    #1;
    start_run(b);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_finished !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_flags: got busy=%b fin=%b expected 0 0", o_busy, o_finished);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_data[c] !== 16'h0000) begin
        errors++; $display("[TB] FAIL abort_data ch%0d: got %h expected 0000", c, o_data[c]);
      end
    end
    seen_fin = 1'b0;
    repeat (12) begin
      @(posedge i_clk);
      #1;
      if (o_finished) seen_fin = 1'b1;
    end
    checks++;
    if (seen_fin !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_finish: got %b expected 0", seen_fin);
    end
    start_run(cv);
    wait_finish(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++; $display("[TB] FAIL abort_restart_latency: got %0d expected 8", cyc);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_data[c] !== model(c, cv[c])) begin
        errors++; $display("[TB] FAIL abort_restart ch%0d: got %h expected %h", c, o_data[c], model(c, cv[c]));
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    $display("[TB] starting denormalizer bench");
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
